// File: rtl/game_board.sv
// rtl/game_board.sv - 2048 game engine: 4x4 board of tile exponents, slide/merge moves, LFSR spawns, win/dead flags
module game_board #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  MAX_TYPE  = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        ld_en,
    input  logic [3:0]  ld_id,
    input  logic [3:0]  ld_type,
    input  logic [3:0]  BlockID,
    output logic [3:0]  BlockType,
    output logic        isDead,
    output logic        isWin,
    output logic [15:0] move_cnt
);
    typedef enum logic [3:0] {
        IDLE, INIT1, INIT2, READY, SHIFT, CHECK, SPAWN, DEADCHK, DEAD
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  board [16];
    logic [15:0] lfsr;
    logic [1:0]  dir;
    logic [1:0]  k;
    logic        changed;
    logic        accept;

    logic [3:0]  line_idx [4];
    logic [3:0]  line_in  [4];
    logic [3:0]  line_out [4];
    logic [3:0]  pk       [5];
    logic [1:0]  pcnt;
    logic [1:0]  ocnt;
    logic        skip;
    logic        line_win;
    logic        line_diff;

    logic        spawn_hit;
    logic [3:0]  spawn_idx;
    logic [3:0]  spawn_val;
    logic [3:0]  scan;
    logic        any_move;

    assign accept    = move_valid && move_ready;
    assign BlockType = board[BlockID];
    assign spawn_val = (lfsr[11:8] == 4'd0) ? 4'd2 : 4'd1;

    // Position j=0 of the line is the destination edge of the slide.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            line_idx[j] = '0;
            case (dir)
                2'd0:    line_idx[j] = {2'(j), k};
                2'd1:    line_idx[j] = {2'(3 - j), k};
                2'd2:    line_idx[j] = {k, 2'(j)};
                default: line_idx[j] = {k, 2'(3 - j)};
            endcase
            line_in[j] = board[line_idx[j]];
        end
    end

    // Compact non-zero tiles toward the edge, then merge equal neighbours once each.
    always_comb begin
        for (int j = 0; j < 5; j++) pk[j] = '0;
        pcnt = '0;
        for (int j = 0; j < 4; j++) begin
            if (line_in[j] != 4'd0) begin
                pk[{1'b0, pcnt}] = line_in[j];
                pcnt = pcnt + 2'd1;
            end
        end
        for (int j = 0; j < 4; j++) line_out[j] = '0;
        ocnt     = '0;
        skip     = 1'b0;
        line_win = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (pk[j] != 4'd0) begin
                if (pk[j] == pk[j+1] && pk[j] != MAX_TYPE) begin
                    line_out[ocnt] = pk[j] + 4'd1;
                    if (pk[j] + 4'd1 == MAX_TYPE) line_win = 1'b1;
                    skip = 1'b1;
                end else begin
                    line_out[ocnt] = pk[j];
                end
                ocnt = ocnt + 2'd1;
            end
        end
        line_diff = 1'b0;
        for (int j = 0; j < 4; j++)
            if (line_out[j] != line_in[j]) line_diff = 1'b1;
    end

    // First empty cell at or after lfsr[3:0], wrapping around the board.
    always_comb begin
        spawn_hit = 1'b0;
        spawn_idx = lfsr[3:0];
        scan      = '0;
        for (int i = 0; i < 16; i++) begin
            scan = lfsr[3:0] + 4'(i);
            if (!spawn_hit && board[scan] == 4'd0) begin
                spawn_hit = 1'b1;
                spawn_idx = scan;
            end
        end
    end

    always_comb begin
        any_move = 1'b0;
        for (int i = 0; i < 16; i++)
            if (board[i] == 4'd0) any_move = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (board[4*r+c] == board[4*r+c+1]) any_move = 1'b1;
        for (int i = 0; i < 12; i++)
            if (board[i] == board[i+4]) any_move = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = INIT1;
        end else begin
            case (state)
                INIT1:   state_nxt = INIT2;
                INIT2:   state_nxt = READY;
                READY:   if (accept) state_nxt = SHIFT;
                SHIFT:   if (k == 2'd3) state_nxt = CHECK;
                CHECK:   state_nxt = changed ? SPAWN : READY;
                SPAWN:   state_nxt = DEADCHK;
                DEADCHK: state_nxt = any_move ? READY : DEAD;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        move_ready = 1'b0;
        if (state == READY && !ld_en) move_ready = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) board[i] <= '0;
            lfsr     <= LFSR_SEED;
            dir      <= '0;
            k        <= '0;
            changed  <= 1'b0;
            isDead   <= 1'b0;
            isWin    <= 1'b0;
            move_cnt <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (start) begin
                for (int i = 0; i < 16; i++) board[i] <= '0;
                isDead   <= 1'b0;
                isWin    <= 1'b0;
                move_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (ld_en) board[ld_id] <= ld_type;
                    READY: begin
                        if (ld_en) begin
                            board[ld_id] <= ld_type;
                        end else if (accept) begin
                            dir     <= move_dir;
                            k       <= '0;
                            changed <= 1'b0;
                        end
                    end
                    INIT1, INIT2, SPAWN: if (spawn_hit) board[spawn_idx] <= spawn_val;
                    SHIFT: begin
                        for (int j = 0; j < 4; j++) board[line_idx[j]] <= line_out[j];
                        changed <= changed | line_diff;
                        isWin   <= isWin | line_win;
                        k       <= k + 2'd1;
                    end
                    CHECK: if (changed && move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
                    DEADCHK: if (!any_move) isDead <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_game_board.sv
// tb/tb_game_board.sv - randomized self-checking bench for game_board against a queue-based 2048 model
module tb_game_board;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = '0;
    logic        move_ready;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_id = '0;
    logic [3:0]  ld_type = '0;
    logic [3:0]  BlockID = '0;
    logic [3:0]  BlockType;
    logic        isDead;
    logic        isWin;
    logic [15:0] move_cnt;

    game_board dut (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
        .move_dir(move_dir), .move_ready(move_ready), .ld_en(ld_en),
        .ld_id(ld_id), .ld_type(ld_type), .BlockID(BlockID),
        .BlockType(BlockType), .isDead(isDead), .isWin(isWin), .move_cnt(move_cnt)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m[16];
    int rb[16];
    int ld_v[16];
    int mcnt;
    bit mwin;
    bit mdead;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Called just after a falling edge; the reads finish well before the next rising edge.
    task automatic read_board();
        for (int i = 0; i < 16; i++) begin
            BlockID = 4'(i);
            #1;
            rb[i] = int'(BlockType);
        end
    endtask

    function automatic bit model_dead();
        for (int i = 0; i < 16; i++) if (m[i] == 0) return 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (c < 3 && m[4*r+c] == m[4*r+c+1]) return 1'b0;
                if (r < 3 && m[4*r+c] == m[4*(r+1)+c]) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic model_shift(input int d, output bit chg, output bit win);
        int q[$];
        int o[$];
        int idx[4];
        int v;
        chg = 1'b0;
        win = 1'b0;
        for (int ln = 0; ln < 4; ln++) begin
            q.delete();
            o.delete();
            for (int j = 0; j < 4; j++) begin
                case (d)
                    0:       idx[j] = 4*j + ln;
                    1:       idx[j] = 4*(3-j) + ln;
                    2:       idx[j] = 4*ln + j;
                    default: idx[j] = 4*ln + 3 - j;
                endcase
                if (m[idx[j]] != 0) q.push_back(m[idx[j]]);
            end
            while (q.size() > 0) begin
                if (q.size() >= 2 && q[0] == q[1] && q[0] != 10) begin
                    o.push_back(q[0] + 1);
                    if (q[0] + 1 == 10) win = 1'b1;
                    void'(q.pop_front());
                    void'(q.pop_front());
                end else begin
                    o.push_back(q.pop_front());
                end
            end
            for (int j = 0; j < 4; j++) begin
                v = (j < o.size()) ? o[j] : 0;
                if (m[idx[j]] != v) chg = 1'b1;
                m[idx[j]] = v;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!move_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(move_ready), 1);
    endtask

    task automatic do_start();
        int n;
        int nz;
        int bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_latency", n, 3);
        read_board();
        nz = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (rb[i] != 0) nz++;
            if (rb[i] > 2) bad++;
            m[i] = rb[i];
        end
        chk("start_tiles", nz, 2);
        chk("start_tile_val", bad, 0);
        mcnt = 0;
        mwin = 1'b0;
        mdead = 1'b0;
        chk("start_cnt", int'(move_cnt), 0);
        chk("start_win", int'(isWin), 0);
        chk("start_dead", int'(isDead), 0);
    endtask

    task automatic load_board();
        wait_ready();
        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1;
            ld_id = 4'(i);
            ld_type = 4'(ld_v[i]);
            if (i == 0) begin
                #1;
                chk("ready_during_ld", int'(move_ready), 0);
            end
            @(negedge clk);
        end
        ld_en = 1'b0;
        for (int i = 0; i < 16; i++) m[i] = ld_v[i];
    endtask

    task automatic do_move(input int d);
        bit chg;
        bit win;
        int n;
        int sp;
        model_shift(d, chg, win);
        wait_ready();
        move_valid = 1'b1;
        move_dir = 2'(d);
        @(negedge clk);
        move_valid = 1'b0;
        n = 1;
        while (!move_ready && !isDead && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_dir%0d", d), n, chg ? 8 : 6);
        read_board();
        sp = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i] != 0 || !chg) begin
                chk($sformatf("cell%0d", i), rb[i], m[i]);
            end else if (rb[i] != 0) begin
                sp++;
                chk($sformatf("spawn_val%0d", i), int'(rb[i] == 1 || rb[i] == 2), 1);
                m[i] = rb[i];
            end
        end
        chk("spawn_count", sp, chg ? 1 : 0);
        if (chg) begin
            if (mcnt < 65535) mcnt++;
            mdead = model_dead();
        end
        mwin = mwin | win;
        chk("move_cnt", int'(move_cnt), mcnt);
        chk("is_win", int'(isWin), int'(mwin));
        chk("is_dead", int'(isDead), int'(mdead));
        chk("ready_after", int'(move_ready), int'(!mdead));
    endtask

    initial begin
        int nz;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        read_board();
        nz = 0;
        for (int i = 0; i < 16; i++) if (rb[i] != 0) nz++;
        chk("rst_cells", nz, 0);
        chk("rst_ready", int'(move_ready), 0);
        chk("rst_dead", int'(isDead), 0);
        chk("rst_win", int'(isWin), 0);
        chk("rst_cnt", int'(move_cnt), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(move_ready), 0);

        do_start();

        ld_v = '{1,1,2,2, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load_board();
        do_move(2);

        ld_v = '{1,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load_board();
        do_move(3);
        ld_v = '{1,0,0,0, 0,0,0,0, 1,0,0,0, 1,0,0,0};
        load_board();
        do_move(0);

        ld_v = '{1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load_board();
        do_move(2);

        ld_v = '{1,2,1,2, 2,1,2,1, 3,4,3,4, 5,6,7,0};
        load_board();
        do_move(3);
        repeat (5) @(negedge clk);
        chk("dead_ready_stays", int'(move_ready), 0);
        chk("dead_sticky", int'(isDead), 1);
        do_start();

        for (int it = 0; it < 40; it++) begin
            if (mdead) do_start();
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < 16; i++)
                    ld_v[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10));
                load_board();
            end
            do_move(int'($urandom_range(0, 3)));
        end
        if (mdead) do_start();

        ld_v = '{9,9,10,10, 0,0,0,0, 0,0,0,0, 0,0,0,0};
        load_board();
        wait_ready();
        move_valid = 1'b1;
        move_dir = 2'd2;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        read_board();
        chk("win_row0_c0", rb[0], 10);
        chk("win_row0_c1", rb[1], 10);
        chk("win_row0_c2", rb[2], 10);
        chk("win_row0_c3", rb[3], 0);
        chk("win_flag", int'(isWin), 1);
        rst = 1'b0;
        #1;
        read_board();
        nz = 0;
        for (int i = 0; i < 16; i++) if (rb[i] != 0) nz++;
        chk("midmove_rst_cells", nz, 0);
        chk("midmove_rst_win", int'(isWin), 0);
        chk("midmove_rst_cnt", int'(move_cnt), 0);
        chk("midmove_rst_ready", int'(move_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
